// File: rtl/divisor_pkg.sv
// Shared types and defaults for the run-time programmable clock-enable scheduler.
package divisor_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    APPLY
  } state_e;

endpackage

// File: rtl/divisor_channel.sv
// One scheduler channel: half-period counter, active/shadow ratio, tick and square-wave output.
module divisor_channel #(
  parameter int unsigned            CNT_W   = 16,
  parameter logic [CNT_W-1:0]       DIV_RST = CNT_W'(1)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic             load_now,
  input  logic             sync,
  input  logic [CNT_W-1:0] value,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_tick;
  logic             r_clk;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_running;
  logic             w_wrap;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_running = (r_div != '0);
  assign w_wrap    = w_running && (w_cnt_inc == r_div);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_div     <= DIV_RST;
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_clk     <= 1'b0;
    end else if (sync) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      if (load_now) begin
        r_div     <= value;
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_div     <= r_shadow;
        r_pending <= 1'b0;
      end
    end else begin
      if (!w_running) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        if (r_pending) begin
          r_div     <= r_shadow;
          r_pending <= 1'b0;
          // Loading a zero ratio parks the output low instead of toggling.
          r_clk     <= (r_shadow == '0) ? 1'b0 : ~r_clk;
        end else begin
          r_clk <= ~r_clk;
        end
      end else begin
        r_cnt  <= w_cnt_inc;
        r_tick <= 1'b0;
      end
      // A write lands after the wrap so it wins over a same-edge shadow consume.
      if (load) begin
        if (!w_running) begin
          r_div <= value;
          r_cnt <= '0;
          r_clk <= 1'b0;
        end else begin
          r_shadow  <= value;
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk;
  assign pending = r_pending;

endmodule

// File: rtl/divisor_scheduler.sv
// Multi-channel clock-enable scheduler: config FSM, capture registers and channel decode.
module divisor_scheduler
  import divisor_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV_INIT = 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  input  logic                    cfg_sync,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         pending
);

  localparam int unsigned CH_W = $clog2(N_CH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_div;
  logic             r_sync;
  logic             w_xfer;
  logic             w_ch_ok;
  logic             w_apply;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    unique case (r_state)
      INIT:  w_state_nxt = IDLE;
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) w_state_nxt = APPLY;
      end
      APPLY: w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  assign w_xfer = cfg_valid && cfg_ready;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_ch   <= '0;
      r_div  <= '0;
      r_sync <= 1'b0;
    end else if (w_xfer) begin
      r_ch   <= cfg_ch;
      r_div  <= cfg_div;
      r_sync <= cfg_sync;
    end
  end

  // Only a non power-of-two channel count can address a missing channel.
  if (N_CH == (1 << CH_W)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_ch_ok = (32'(r_ch) < N_CH);
  end

  assign w_apply = (r_state == APPLY) && w_ch_ok;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic w_hit;
    assign w_hit = w_apply && (r_ch == CH_W'(gi));

    divisor_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (CNT_W'(DIV_INIT << gi))
    ) u_channel (
      .clk_in   (clk_in),
      .reset    (reset),
      .load     (w_hit && !r_sync),
      .load_now (w_hit && r_sync),
      .sync     (w_apply && r_sync),
      .value    (r_div),
      .tick     (tick[gi]),
      .clk_out  (clk_out[gi]),
      .pending  (pending[gi])
    );
  end

endmodule
